// File: rtl/mem_bridge_pkg.sv
// rtl/mem_bridge_pkg.sv - shared state encoding and default geometry for mem_host_bridge
package mem_bridge_pkg;

  localparam int DATA_WIDTH_DEF = 36;
  localparam int ADDR_WIDTH_DEF = 12;
  localparam int DEPTH_DEF      = 4096;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    DUMP_RD,
    DUMP_OUT
  } state_t;

endpackage

// File: rtl/dp_ram_rf.sv
// rtl/dp_ram_rf.sv - single-port RAM, registered read-first output with read enable
module dp_ram_rf #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  re,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_host_bridge.sv
// rtl/mem_host_bridge.sv - host load / processor data memory / result dump bridge
module mem_host_bridge
  import mem_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  input  logic [ADDR_WIDTH-1:0] dump_base,
  input  logic [ADDR_WIDTH:0]   dump_count,
  output logic                  core_rstN,
  output logic                  startN,
  input  logic [ADDR_WIDTH-1:0] dataMemAddr,
  input  logic                  DataMemWrEn,
  input  logic [DATA_WIDTH-1:0] ProcessorDataOut,
  output logic [DATA_WIDTH-1:0] ProcessorDataIn,
  input  logic                  done,
  output logic                  dp_valid,
  input  logic                  dp_ready,
  output logic [DATA_WIDTH-1:0] dp_data,
  output logic                  dp_last,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [ADDR_WIDTH:0]     cnt;
  logic [ADDR_WIDTH-1:0]   base_r;
  logic [ADDR_WIDTH:0]     count_r;
  logic                    run_q;
  logic [DATA_WIDTH-1:0]   pdi_hold;
  logic                    ld_fire;
  logic                    load_done;
  logic                    ram_re, ram_we;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0]   ram_wdata, ram_rdata;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ld_ready   = 1'b0;
    core_rstN  = 1'b1;
    startN     = 1'b1;
    dp_valid   = 1'b0;
    dp_last    = 1'b0;
    load_done  = 1'b0;
    ram_re     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = ptr;
    ram_wdata  = ld_data;
    ld_fire    = 1'b0;
    unique case (state)
      IDLE: begin
        ld_ready  = 1'b1;
        core_rstN = 1'b0;
        ld_fire   = ld_valid;
        ram_addr  = '0;
        ram_we    = ld_fire;
        load_done = ld_fire && ld_last;
        if (ld_fire) state_next = load_done ? START : LOAD;
      end
      LOAD: begin
        ld_ready  = 1'b1;
        core_rstN = 1'b0;
        ld_fire   = ld_valid;
        ram_we    = ld_fire;
        load_done = ld_fire && (ld_last || ptr == LAST_ADDR);
        if (load_done) state_next = START;
      end
      START: begin
        startN     = 1'b0;
        state_next = RUN;
      end
      RUN: begin
        ram_re    = 1'b1;
        ram_we    = DataMemWrEn;
        ram_addr  = dataMemAddr;
        ram_wdata = ProcessorDataOut;
        if (done) state_next = (count_r == '0) ? IDLE : DUMP_RD;
      end
      DUMP_RD: begin
        ram_re     = 1'b1;
        state_next = DUMP_OUT;
      end
      DUMP_OUT: begin
        dp_valid = 1'b1;
        dp_last  = (cnt == (ADDR_WIDTH + 1)'(1));
        if (dp_ready) state_next = dp_last ? IDLE : DUMP_RD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      cnt      <= '0;
      base_r   <= '0;
      count_r  <= '0;
      run_q    <= 1'b0;
      pdi_hold <= '0;
    end else begin
      run_q <= (state == RUN);
      if (run_q) pdi_hold <= ram_rdata;
      if (load_done) begin
        base_r  <= dump_base;
        count_r <= (dump_count > DEPTH_W) ? DEPTH_W : dump_count;
      end
      case (state)
        IDLE:     if (ld_fire) ptr <= ADDR_WIDTH'(1);
        LOAD:     if (ld_fire) ptr <= ptr + 1'b1;
        RUN:      if (done) begin
                    ptr <= base_r;
                    cnt <= count_r;
                  end
        DUMP_OUT: if (dp_ready) begin
                    ptr <= ptr + 1'b1;
                    cnt <= cnt - 1'b1;
                  end
        default: ;
      endcase
    end
  end

  // The RAM output register is shared by processor reads and dump reads, so the
  // processor-facing value is frozen in pdi_hold once RUN is left.
  assign ProcessorDataIn = run_q ? ram_rdata : pdi_hold;
  assign dp_data         = (state == DUMP_OUT) ? ram_rdata : '0;
  assign busy            = (state != IDLE);

  dp_ram_rf #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .re   (ram_re),
    .we   (ram_we && !rst),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_mem_host_bridge.sv
// tb/tb_mem_host_bridge.sv - directed self-checking bench for mem_host_bridge
module tb_mem_host_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid, ld_ready, ld_last;
  logic [35:0] ld_data;
  logic [11:0] dump_base;
  logic [12:0] dump_count;
  logic        core_rstN, startN;
  logic [11:0] dataMemAddr;
  logic        DataMemWrEn;
  logic [35:0] ProcessorDataOut, ProcessorDataIn;
  logic        done;
  logic        dp_valid, dp_ready, dp_last;
  logic [35:0] dp_data;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [35:0] held;

  always #5 clk = ~clk;

  mem_host_bridge dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .dump_base(dump_base), .dump_count(dump_count),
    .core_rstN(core_rstN), .startN(startN),
    .dataMemAddr(dataMemAddr), .DataMemWrEn(DataMemWrEn),
    .ProcessorDataOut(ProcessorDataOut), .ProcessorDataIn(ProcessorDataIn),
    .done(done),
    .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_data(dp_data), .dp_last(dp_last),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 8; i++) begin
      if (dp_valid) break;
      tick();
    end
    check("dp_valid_wait", dp_valid, 1);
  endtask

  task automatic dump_expect(input string tag, input logic [35:0] exp, input logic last);
    wait_valid();
    check({tag, "_data"}, dp_data, exp);
    check({tag, "_last"}, dp_last, last);
    tick();
  endtask

  task automatic load_one(input logic [35:0] d, input logic [11:0] b, input logic [12:0] c);
    ld_valid = 1; ld_data = d; ld_last = 1; dump_base = b; dump_count = c;
    tick();
    ld_valid = 0; ld_last = 0;
    tick();
  endtask

  task automatic proc_write(input logic [11:0] a, input logic [35:0] d);
    dataMemAddr = a; ProcessorDataOut = d; DataMemWrEn = 1;
    tick();
    DataMemWrEn = 0;
  endtask

  initial begin
    rst = 1; ld_valid = 0; ld_data = '0; ld_last = 0; dump_base = '0; dump_count = '0;
    dataMemAddr = '0; DataMemWrEn = 0; ProcessorDataOut = '0; done = 0; dp_ready = 0;
    tick(); tick();
    rst = 0;
    check("rst_busy", busy, 0);
    check("rst_ld_ready", ld_ready, 1);
    check("rst_core_rstN", core_rstN, 0);
    check("rst_startN", startN, 1);
    check("rst_dp_valid", dp_valid, 0);
    check("rst_pdi", ProcessorDataIn, 0);

    ld_valid = 1; ld_data = 36'h000000001; ld_last = 0;
    tick();
    check("load_busy", busy, 1);
    check("load_ready", ld_ready, 1);
    ld_data = 36'h000000002;
    tick();
    ld_data = 36'h000000003; ld_last = 1; dump_base = 12'd5; dump_count = 13'd3;
    tick();
    ld_valid = 0; ld_last = 0;
    check("start_startN", startN, 0);
    check("start_core_rstN", core_rstN, 1);
    check("start_ld_ready", ld_ready, 0);
    tick();
    check("run_startN", startN, 1);
    dataMemAddr = 12'd2;
    tick();
    check("run_rd2", ProcessorDataIn, 36'h000000003);
    dataMemAddr = 12'd0;
    tick();
    check("run_rd0", ProcessorDataIn, 36'h000000001);

    proc_write(12'd5, 36'h000000555);
    proc_write(12'd5, 36'hABCABCABC);
    check("collide_old", ProcessorDataIn, 36'h000000555);
    dataMemAddr = 12'd5;
    tick();
    check("collide_new", ProcessorDataIn, 36'hABCABCABC);
    proc_write(12'd6, 36'h000000666);
    proc_write(12'd7, 36'h000000777);
    proc_write(12'd4094, 36'h000000FFE);
    proc_write(12'd4095, 36'h000000FFF);

    dataMemAddr = 12'd2; done = 1;
    tick();
    done = 0;
    check("dumprd_valid", dp_valid, 0);
    check("dumprd_pdi", ProcessorDataIn, 36'h000000003);
    wait_valid();
    check("bp_data", dp_data, 36'hABCABCABC);
    check("bp_last", dp_last, 0);
    held = dp_data;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_valid_hold", dp_valid, 1);
      check("bp_data_hold", dp_data, held);
    end
    dp_ready = 1;
    tick();
    dump_expect("d6", 36'h000000666, 0);
    dump_expect("d7", 36'h000000777, 1);
    check("dump_end_busy", busy, 0);
    check("dump_end_pdi_hold", ProcessorDataIn, 36'h000000003);

    proc_write(12'd6, 36'h000000BAD);

    load_one(36'h000000001, 12'd0, 13'd0);
    done = 1;
    tick();
    done = 0;
    check("zero_busy", busy, 0);
    check("zero_dp_valid", dp_valid, 0);
    tick();
    check("zero_dp_valid2", dp_valid, 0);

    load_one(36'h000000001, 12'd4094, 13'd3);
    done = 1;
    tick();
    done = 0;
    dump_expect("w4094", 36'h000000FFE, 0);
    dump_expect("w4095", 36'h000000FFF, 0);
    dump_expect("w0", 36'h000000001, 1);
    check("wrap_busy", busy, 0);

    dp_ready = 0;
    load_one(36'h000000001, 12'd5, 13'd3);
    done = 1;
    tick();
    done = 0;
    wait_valid();
    rst = 1;
    tick();
    rst = 0;
    check("midrst_dp_valid", dp_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ld_ready", ld_ready, 1);
    check("midrst_dp_data", dp_data, 0);
    check("midrst_core_rstN", core_rstN, 0);

    dp_ready = 1;
    load_one(36'h000000001, 12'd5, 13'd3);
    done = 1;
    tick();
    done = 0;
    dump_expect("r5", 36'hABCABCABC, 0);
    dump_expect("r6", 36'h000000666, 0);
    dump_expect("r7", 36'h000000777, 1);
    check("reload_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
